// File: rtl/l2_fwd_stall_pkg.sv
// Shared types and constants for the L2 forward-stall slice.
// spandex_types / spandex_consts mirror the codebase packages this block
// depends on; l2_fwd_stall_pkg holds the block-local helpers.

package spandex_types;
  typedef logic [4:0]  mix_msg_t;
  typedef logic [27:0] line_addr_t;
  typedef logic [3:0]  cache_id_t;
  typedef logic [4:0]  unstable_state_t;
endpackage

package spandex_consts;
  import spandex_types::*;

  localparam int N_REQS    = 8;
  localparam int REQS_BITS = 3;

  // Request-buffer transient states
  localparam unstable_state_t INVALID = 5'd0;
  localparam unstable_state_t ISD     = 5'd1;
  localparam unstable_state_t IMAD    = 5'd2;
  localparam unstable_state_t IMA     = 5'd3;
  localparam unstable_state_t MIA     = 5'd4;

  // Forward opcodes
  localparam mix_msg_t FWD_GETS    = 5'd1;
  localparam mix_msg_t FWD_GETM    = 5'd2;
  localparam mix_msg_t FWD_INV     = 5'd3;
  localparam mix_msg_t FWD_INV_LLC = 5'd4;

  // Request-buffer operation the top selects while peek_fwd is high
  localparam logic [2:0] L2_REQS_PEEK_FWD = 3'd5;
endpackage

package l2_fwd_stall_pkg;
  import spandex_types::*;
  import spandex_consts::*;

  // Forward message as held between capture and issue
  typedef struct packed {
    mix_msg_t   coh_msg;
    line_addr_t addr;
    cache_id_t  req_id;
  } fwd_msg_t;

  localparam logic [15:0] STALL_CYC_MAX = 16'hFFFF;

  // Invalidating forwards only have to wait out a pending ISD fill
  function automatic logic is_inv_fwd(input mix_msg_t msg);
    return (msg == FWD_INV) || (msg == FWD_INV_LLC);
  endfunction
endpackage

// File: rtl/l2_fwd_stall_if.sv
// Forward-message handshake bundle: upstream queue into the stall unit and
// the held message out toward the forward handler.

interface l2_fwd_stall_if;
  import spandex_types::*;

  logic       fwd_in_valid;
  logic       fwd_in_ready;
  mix_msg_t   fwd_in_coh_msg;
  line_addr_t fwd_in_addr;
  cache_id_t  fwd_in_req_id;

  logic       fwd_out_valid;
  logic       fwd_out_ready;
  mix_msg_t   fwd_out_coh_msg;
  line_addr_t fwd_out_addr;
  cache_id_t  fwd_out_req_id;
  logic       fwd_out_replay;

  // Environment side: offers forwards, consumes issued ones
  modport master (
    output fwd_in_valid, fwd_in_coh_msg, fwd_in_addr, fwd_in_req_id,
    input  fwd_in_ready,
    input  fwd_out_valid, fwd_out_coh_msg, fwd_out_addr, fwd_out_req_id,
    input  fwd_out_replay,
    output fwd_out_ready
  );

  // Stall unit side
  modport slave (
    input  fwd_in_valid, fwd_in_coh_msg, fwd_in_addr, fwd_in_req_id,
    output fwd_in_ready,
    output fwd_out_valid, fwd_out_coh_msg, fwd_out_addr, fwd_out_req_id,
    output fwd_out_replay,
    input  fwd_out_ready
  );
endinterface

// File: rtl/l2_fwd_stall.sv
// L2 forward stall unit: captures one forward, asks the request buffer
// whether it conflicts with an outstanding request, parks it until that
// entry reaches a safe state, then issues it downstream.

module l2_fwd_stall
  import spandex_types::*;
  import spandex_consts::*;
  import l2_fwd_stall_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  l2_fwd_stall_if.slave                        bus,
  output logic                                 peek_fwd,
  input  logic                                 set_fwd_stall,
  input  logic                                 clr_fwd_stall,
  input  logic [REQS_BITS-1:0]                 fwd_stall_i_wr_data,
  input  unstable_state_t [N_REQS-1:0]         reqs_state,
  output logic                                 fwd_stall,
  output logic [REQS_BITS-1:0]                 fwd_stall_i,
  output logic [15:0]                          stall_cycles
);

  typedef enum logic [1:0] {IDLE, PEEK, STALL, ISSUE} state_t;

  state_t               state_reg;
  fwd_msg_t             held_reg;
  logic                 in_ready_reg;
  logic                 peek_reg;
  logic                 stall_reg;
  logic [REQS_BITS-1:0] stall_i_reg;
  logic [15:0]          stall_cyc_reg;
  logic                 out_valid_reg;
  logic                 replay_reg;

  unstable_state_t      entry_state;
  logic                 stall_done;

  // Release test on the live state of the conflicting entry
  always_comb begin
    entry_state = reqs_state[stall_i_reg];
    stall_done  = (entry_state == INVALID) ||
                  (is_inv_fwd(held_reg.coh_msg) ? (entry_state != ISD)
                                                : (entry_state == MIA));
  end

  // Control FSM with registered outputs; reset drops any held message
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      held_reg      <= '0;
      in_ready_reg  <= 1'b1;
      peek_reg      <= 1'b0;
      stall_reg     <= 1'b0;
      stall_i_reg   <= '0;
      stall_cyc_reg <= '0;
      out_valid_reg <= 1'b0;
      replay_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.fwd_in_valid) begin
            held_reg      <= '{coh_msg: bus.fwd_in_coh_msg,
                               addr:    bus.fwd_in_addr,
                               req_id:  bus.fwd_in_req_id};
            stall_cyc_reg <= '0;
            in_ready_reg  <= 1'b0;
            peek_reg      <= 1'b1;
            state_reg     <= PEEK;
          end
        end
        PEEK: begin
          // A stall verdict wins over a clear in the same cycle
          if (set_fwd_stall) begin
            peek_reg    <= 1'b0;
            stall_reg   <= 1'b1;
            stall_i_reg <= fwd_stall_i_wr_data;
            state_reg   <= STALL;
          end else if (clr_fwd_stall) begin
            peek_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            replay_reg    <= 1'b0;
            state_reg     <= ISSUE;
          end
        end
        STALL: begin
          if (stall_cyc_reg != STALL_CYC_MAX) begin
            stall_cyc_reg <= stall_cyc_reg + 16'd1;
          end
          if (stall_done) begin
            stall_reg     <= 1'b0;
            out_valid_reg <= 1'b1;
            replay_reg    <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.fwd_out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.fwd_in_ready    = in_ready_reg;
  assign bus.fwd_out_valid   = out_valid_reg;
  assign bus.fwd_out_coh_msg = held_reg.coh_msg;
  assign bus.fwd_out_addr    = held_reg.addr;
  assign bus.fwd_out_req_id  = held_reg.req_id;
  assign bus.fwd_out_replay  = replay_reg;
  assign peek_fwd            = peek_reg;
  assign fwd_stall           = stall_reg;
  assign fwd_stall_i         = stall_i_reg;
  assign stall_cycles        = stall_cyc_reg;

endmodule

// File: tb/tb_l2_fwd_stall.sv
// Bench for l2_fwd_stall: directed forward scenarios, a transaction-level
// reference model compared every cycle, plus literal expectations.

module tb_l2_fwd_stall;
  import spandex_types::*;
  import spandex_consts::*;

  logic clk;
  logic rst;
  logic peek_fwd;
  logic set_fwd_stall;
  logic clr_fwd_stall;
  logic [REQS_BITS-1:0] fwd_stall_i_wr_data;
  unstable_state_t [N_REQS-1:0] reqs_state;
  logic fwd_stall;
  logic [REQS_BITS-1:0] fwd_stall_i;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit armed = 0;

  l2_fwd_stall_if bus();

  l2_fwd_stall dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus.slave),
    .peek_fwd            (peek_fwd),
    .set_fwd_stall       (set_fwd_stall),
    .clr_fwd_stall       (clr_fwd_stall),
    .fwd_stall_i_wr_data (fwd_stall_i_wr_data),
    .reqs_state          (reqs_state),
    .fwd_stall           (fwd_stall),
    .fwd_stall_i         (fwd_stall_i),
    .stall_cycles        (stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The unit is described by what it is visibly doing: accepting (ready),
  // asking (peek), parked (stall) or offering (valid).
  typedef struct packed {
    logic                 ready;
    logic                 peek;
    logic                 stall;
    logic [REQS_BITS-1:0] idx;
    logic [15:0]          ncyc;
    logic                 valid;
    logic                 replay;
    mix_msg_t             msg;
    line_addr_t           addr;
    cache_id_t            id;
  } mstate_t;

  localparam mstate_t M_RST = '{ready: 1'b1, default: '0};
  mstate_t m = M_RST;

  function automatic logic may_go(input mix_msg_t op, input unstable_state_t s);
    if (s == INVALID) return 1'b1;
    if (op == FWD_INV || op == FWD_INV_LLC) return s != ISD;
    return s == MIA;
  endfunction

  function automatic mstate_t step(input mstate_t c, input logic iv, input mix_msg_t im,
                                   input line_addr_t ia, input cache_id_t ii,
                                   input logic st, input logic cl,
                                   input logic [REQS_BITS-1:0] wd,
                                   input unstable_state_t s, input logic ordy);
    mstate_t n = c;
    if (c.ready) begin
      if (iv) begin
        n.msg = im; n.addr = ia; n.id = ii;
        n.ncyc = 0; n.ready = 0; n.peek = 1;
      end
    end else if (c.peek) begin
      if (st) begin
        n.peek = 0; n.stall = 1; n.idx = wd;
      end else if (cl) begin
        n.peek = 0; n.valid = 1; n.replay = 0;
      end
    end else if (c.stall) begin
      n.ncyc = (c.ncyc == 16'hFFFF) ? c.ncyc : c.ncyc + 16'd1;
      if (may_go(c.msg, s)) begin
        n.stall = 0; n.valid = 1; n.replay = 1;
      end
    end else if (c.valid && ordy) begin
      n.valid = 0; n.ready = 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= M_RST;
    else m <= step(m, bus.fwd_in_valid, bus.fwd_in_coh_msg, bus.fwd_in_addr,
                   bus.fwd_in_req_id, set_fwd_stall, clr_fwd_stall,
                   fwd_stall_i_wr_data, reqs_state[m.idx], bus.fwd_out_ready);
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("cycle_outputs",
          64'({bus.fwd_in_ready, peek_fwd, fwd_stall, fwd_stall_i, stall_cycles,
               bus.fwd_out_valid, bus.fwd_out_replay, bus.fwd_out_coh_msg,
               bus.fwd_out_addr, bus.fwd_out_req_id}),
          64'({m.ready, m.peek, m.stall, m.idx, m.ncyc, m.valid, m.replay,
               m.msg, m.addr, m.id}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer a forward; t returns the cycle in which it was accepted
  task automatic offer(input mix_msg_t op, input line_addr_t a, input cache_id_t id,
                       output int t);
    int n = 0;
    bus.fwd_in_valid   = 1'b1;
    bus.fwd_in_coh_msg = op;
    bus.fwd_in_addr    = a;
    bus.fwd_in_req_id  = id;
    while (!bus.fwd_in_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!bus.fwd_in_ready) chk("offer_timeout", 0, 1);
    t = cyc;
    tick(1);
    bus.fwd_in_valid = 1'b0;
    $display("offer op=%0d addr=%0h id=%0h at cycle %0d", op, a, id, t);
  endtask

  task automatic verdict(input bit st, input bit cl, input logic [REQS_BITS-1:0] idx);
    set_fwd_stall       = st;
    clr_fwd_stall       = cl;
    fwd_stall_i_wr_data = idx;
    tick(1);
    set_fwd_stall = 1'b0;
    clr_fwd_stall = 1'b0;
  endtask

  // Drive entry idx with s_hold for n_hold stall cycles, then s_final
  task automatic stall_run(input int idx, input unstable_state_t s_hold, input int n_hold,
                           input unstable_state_t s_final, output int n);
    n = 0;
    while (fwd_stall && n < 200) begin
      n++;
      reqs_state[idx] = (n <= n_hold) ? s_hold : s_final;
      tick(1);
    end
    if (fwd_stall) chk("stall_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (!bus.fwd_out_valid && n < 50) begin
      tick(1);
      n++;
    end
    if (!bus.fwd_out_valid) chk("valid_timeout", 0, 1);
    t = cyc;
  endtask

  // Consume the issued forward after holding ready low for 'hold' cycles
  task automatic take(input int hold, input line_addr_t exp_addr);
    int t;
    wait_valid(t);
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", 64'(bus.fwd_in_ready), 0);
      chk("hold_out_valid", 64'(bus.fwd_out_valid), 1);
      chk("hold_out_addr", 64'(bus.fwd_out_addr), 64'(exp_addr));
      tick(1);
    end
    bus.fwd_out_ready = 1'b1;
    tick(1);
    bus.fwd_out_ready = 1'b0;
    $display("issue addr=%0h replay=%0d stall_cycles=%0d at cycle %0d",
             bus.fwd_out_addr, bus.fwd_out_replay, stall_cycles, cyc);
    chk("ready_after_issue", 64'(bus.fwd_in_ready), 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t, tv, n;
    rst = 1'b1;
    bus.fwd_in_valid = 1'b0;
    bus.fwd_in_coh_msg = '0;
    bus.fwd_in_addr = '0;
    bus.fwd_in_req_id = '0;
    bus.fwd_out_ready = 1'b0;
    set_fwd_stall = 1'b0;
    clr_fwd_stall = 1'b0;
    fwd_stall_i_wr_data = '0;
    for (int i = 0; i < N_REQS; i++) reqs_state[i] = IMAD;

    #2 rst = 1'b0;
    armed = 1'b1;
    tick(3);
    chk("rst_in_ready", 64'(bus.fwd_in_ready), 1);
    chk("rst_stall", 64'(fwd_stall), 0);
    chk("rst_cycles", 64'(stall_cycles), 0);
    chk("rst_out_valid", 64'(bus.fwd_out_valid), 0);
    chk("rst_peek", 64'(peek_fwd), 0);
    rst = 1'b1;
    tick(1);

    // Clean GETS: cleared at peek, issued two cycles after acceptance
    offer(FWD_GETS, 28'h1234567, 4'h2, t);
    chk("gets_peek", 64'(peek_fwd), 1);
    verdict(0, 1, 0);
    wait_valid(tv);
    chk("gets_latency", 64'(tv - t), 2);
    chk("gets_replay", 64'(bus.fwd_out_replay), 0);
    chk("gets_cycles", 64'(stall_cycles), 0);
    take(0, 28'h1234567);

    // GETM stalled on entry 3 until it reaches MIA
    offer(FWD_GETM, 28'h0abcdef, 4'h5, t);
    reqs_state[3] = IMAD;
    verdict(1, 0, 3);
    chk("getm_stall_i", 64'(fwd_stall_i), 3);
    stall_run(3, IMAD, 5, MIA, n);
    chk("getm_stall_len", 64'(n), 6);
    chk("getm_cycles", 64'(stall_cycles), 6);
    chk("getm_replay", 64'(bus.fwd_out_replay), 1);
    take(0, 28'h0abcdef);

    // FWD_INV waits out ISD, released once the entry moves to IMA
    offer(FWD_INV, 28'h0000100, 4'h1, t);
    verdict(1, 0, 1);
    stall_run(1, ISD, 4, IMA, n);
    chk("inv_stall_len", 64'(n), 5);
    chk("inv_cycles", 64'(stall_cycles), 5);
    chk("inv_replay", 64'(bus.fwd_out_replay), 1);
    take(0, 28'h0000100);

    // FWD_INV against an entry already in IMA: cleared, no stall
    offer(FWD_INV, 28'h0000200, 4'h3, t);
    reqs_state[1] = IMA;
    verdict(0, 1, 1);
    wait_valid(tv);
    chk("inv_clr_latency", 64'(tv - t), 2);
    chk("inv_clr_replay", 64'(bus.fwd_out_replay), 0);
    chk("inv_clr_cycles", 64'(stall_cycles), 0);
    take(0, 28'h0000200);

    // FWD_INV_LLC: ISD for 2 cycles, then IMAD releases it
    offer(FWD_INV_LLC, 28'h0000300, 4'h4, t);
    verdict(1, 0, 2);
    stall_run(2, ISD, 2, IMAD, n);
    chk("llc_stall_len", 64'(n), 3);
    take(0, 28'h0000300);

    // No verdict holds PEEK; both verdicts together favour the stall;
    // then a 10-cycle downstream back-pressure
    offer(FWD_GETS, 28'h0fff000, 4'h9, t);
    verdict(0, 0, 0);
    verdict(0, 0, 0);
    chk("peek_hold", 64'(peek_fwd), 1);
    chk("peek_hold_ready", 64'(bus.fwd_in_ready), 0);
    reqs_state[6] = INVALID;
    verdict(1, 1, 6);
    chk("both_stall", 64'(fwd_stall), 1);
    chk("both_stall_i", 64'(fwd_stall_i), 6);
    stall_run(6, INVALID, 0, INVALID, n);
    chk("invalid_release_len", 64'(n), 1);
    take(10, 28'h0fff000);

    // Asynchronous reset while stalled discards the forward
    offer(FWD_GETM, 28'h0555555, 4'h6, t);
    reqs_state[4] = IMAD;
    verdict(1, 0, 4);
    tick(3);
    #3 rst = 1'b0;
    #1;
    chk("arst_stall", 64'(fwd_stall), 0);
    chk("arst_in_ready", 64'(bus.fwd_in_ready), 1);
    chk("arst_cycles", 64'(stall_cycles), 0);
    chk("arst_out_valid", 64'(bus.fwd_out_valid), 0);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("post_rst_ready", 64'(bus.fwd_in_ready), 1);

    // Very long stall saturates the cycle counter
    offer(FWD_GETS, 28'h0777777, 4'h7, t);
    reqs_state[5] = IMAD;
    verdict(1, 0, 5);
    tick(70000);
    chk("sat_cycles", 64'(stall_cycles), 16'hFFFF);
    chk("sat_stall", 64'(fwd_stall), 1);
    reqs_state[5] = INVALID;
    tick(1);
    chk("sat_valid", 64'(bus.fwd_out_valid), 1);
    chk("sat_replay", 64'(bus.fwd_out_replay), 1);
    chk("sat_cycles_held", 64'(stall_cycles), 16'hFFFF);
    take(0, 28'h0777777);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
